// File: rtl/apb_cmd_master.sv
// APB4 initiator: one valid/ready command becomes one APB transfer, answered on a single-entry response channel.
// Optional ACCESS-phase timeout abort is compiled in with `define APB_CMD_MASTER_TIMEOUT_EN.
module apb_cmd_master #(
    parameter int ADDR    = 24,
    parameter int DATA    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR-1:0]   cmd_addr,
    input  logic [DATA-1:0]   cmd_wdata,
    input  logic [DATA/8-1:0] cmd_strb,
    input  logic [2:0]        cmd_prot,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA-1:0]   rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic [2:0]        pprot,
    output logic [ADDR-1:0]   paddr,
    output logic              pwrite,
    output logic [DATA-1:0]   pwdata,
    output logic [DATA/8-1:0] pstrb,
    input  logic [DATA-1:0]   prdata,
    input  logic              pslverr,
    input  logic              pready
);

    if (!(DATA == 8 || DATA == 16 || DATA == 32) || TIMEOUT < 1) begin : g_param_check
        $error("apb_cmd_master: DATA must be 8/16/32 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   accept;
    logic   done;
    logic   abort;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    // Cleared while entering ACCESS, so the first ACCESS cycle sees a count of zero.
    always_ff @(posedge pclk) begin
        if (preset || state != ACCESS)
            tmo_cnt <= '0;
        else if (!pready)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign abort = (state == ACCESS) && !pready && (tmo_cnt == TW'(TIMEOUT - 1));
`else
    assign abort = 1'b0;
`endif

    assign cmd_ready = !preset && (state == IDLE) && (!rsp_valid || rsp_ready);
    assign accept    = cmd_valid && cmd_ready;
    assign done      = (state == ACCESS) && pready;

    always_ff @(posedge pclk) begin
        if (preset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (done || abort) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            pprot     <= '0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            pstrb     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                psel   <= 1'b1;
                pprot  <= cmd_prot;
                paddr  <= cmd_addr;
                pwrite <= cmd_write;
                pwdata <= cmd_wdata;
                pstrb  <= cmd_write ? cmd_strb : '0;
            end
            if (state == SETUP)
                penable <= 1'b1;
            if (rsp_valid && rsp_ready)
                rsp_valid <= 1'b0;
            // A completion never coincides with a pending response, so the load below wins safely.
            if (done) begin
                psel      <= 1'b0;
                penable   <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_rdata <= pwrite ? '0 : prdata;
                rsp_err   <= pslverr;
            end else if (abort) begin
                psel      <= 1'b0;
                penable   <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: APB slave and response consumer driven from fixed vectors.
module tb_apb_cmd_master;

    localparam int ADDR = 24;
    localparam int DATA = 32;

    logic            pclk = 1'b0;
    logic            preset;
    logic            cmd_valid, cmd_ready, cmd_write;
    logic [ADDR-1:0] cmd_addr;
    logic [DATA-1:0] cmd_wdata;
    logic [3:0]      cmd_strb;
    logic [2:0]      cmd_prot;
    logic            rsp_valid, rsp_ready, rsp_err;
    logic [DATA-1:0] rsp_rdata;
    logic            psel, penable, pwrite;
    logic [2:0]      pprot;
    logic [ADDR-1:0] paddr;
    logic [DATA-1:0] pwdata;
    logic [3:0]      pstrb;
    logic [DATA-1:0] prdata;
    logic            pslverr, pready;

    int n_checks = 0;
    int n_errors = 0;

    apb_cmd_master #(.ADDR(ADDR), .DATA(DATA), .TIMEOUT(16)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pprot(pprot), .paddr(paddr), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pslverr(pslverr), .pready(pready)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_cmd(input logic wr, input logic [ADDR-1:0] a, input logic [DATA-1:0] d,
                           input logic [3:0] s, input logic [2:0] p);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
        cmd_prot  = p;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_cleared", rsp_valid, 1'b0);
    endtask

    initial begin
        preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0; prdata = '0; pslverr = 1'b0; pready = 1'b1;
        tick(); tick();
        check("rst_outputs", {psel, penable, pprot, paddr, pwrite, pstrb, rsp_valid, rsp_err}, '0);
        check("rst_data", {pwdata, rsp_rdata}, '0);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        preset = 1'b0;
        #1;
        check("idle_cmd_ready", cmd_ready, 1'b1);

        // Zero-wait write
        set_cmd(1'b1, 24'h000010, 32'hA5A5_5A5A, 4'hF, 3'h2);
        tick();
        cmd_valid = 1'b0;
        check("wr_setup_sel", {psel, penable}, 2'b10);
        check("wr_setup_bus", {paddr, pwdata, pstrb, pprot, pwrite}, {24'h000010, 32'hA5A5_5A5A, 4'hF, 3'h2, 1'b1});
        tick();
        check("wr_access_sel", {psel, penable, rsp_valid}, 3'b110);
        tick();
        check("wr_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h0});
        check("wr_psel_low", {psel, penable}, 2'b00);
        consume();

        // Read with 3 wait states
        pready = 1'b0; prdata = 32'h1234_5678;
        set_cmd(1'b0, 24'h000104, 32'hFFFF_FFFF, 4'hF, 3'h0);
        tick();
        cmd_valid = 1'b0;
        check("rd_setup", {psel, penable, pstrb, pwrite}, {2'b10, 4'h0, 1'b0});
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rd_access%0d", i), {psel, penable, paddr, pstrb, rsp_valid},
                  {2'b11, 24'h000104, 4'h0, 1'b0});
            if (i == 3) pready = 1'b1;
            tick();
        end
        check("rd_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h1234_5678});
        consume();

        // Slave error with response backpressure, then simultaneous handshakes
        pslverr = 1'b1; prdata = 32'h0BAD_0BAD;
        set_cmd(1'b0, 24'h000200, '0, 4'h0, 3'h1);
        tick();
        set_cmd(1'b1, 24'h000300, 32'h0000_00AA, 4'h1, 3'h0);
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("err_hold%0d", i), {rsp_valid, rsp_err, rsp_rdata, cmd_ready, psel},
                  {1'b1, 1'b1, 32'h0BAD_0BAD, 1'b0, 1'b0});
            tick();
        end
        pslverr = 1'b0; rsp_ready = 1'b1;
        #1;
        check("err_both_ready", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        check("err_both_hs", {rsp_valid, psel, paddr}, {1'b0, 1'b1, 24'h000300});
        tick(); tick();
        check("err_next_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h0});
        consume();

        // Back-to-back alternating write/read with rsp_ready held high
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            prdata = 32'hC0DE_0000 + k;
            set_cmd((k % 2) == 0, ADDR'(4 * k), 32'h1111_0000 + k, 4'hF, 3'h0);
            #1;
            check($sformatf("b2b_ready%0d", k), cmd_ready, 1'b1);
            tick();
            cmd_valid = 1'b0;
            check($sformatf("b2b_setup%0d", k), {psel, penable, paddr, pwrite},
                  {2'b10, ADDR'(4 * k), 1'b1 ^ k[0]});
            tick(); tick();
            check($sformatf("b2b_rsp%0d", k), {rsp_valid, rsp_rdata, psel},
                  {1'b1, (k % 2) ? 32'hC0DE_0000 + k : 32'h0, 1'b0});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("b2b_quiet%0d", i), {psel, rsp_valid}, 2'b00);
        end
        rsp_ready = 1'b0;

        // Reset while a read is waiting in ACCESS
        pready = 1'b0;
        set_cmd(1'b0, 24'h000050, '0, 4'h0, 3'h7);
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        check("rst_mid_access", {psel, penable}, 2'b11);
        preset = 1'b1;
        tick();
        check("rst_mid_outputs", {psel, penable, pprot, paddr, pwrite, pstrb, rsp_valid, rsp_err, cmd_ready}, '0);
        preset = 1'b0; pready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rst_no_rsp%0d", i), {rsp_valid, psel}, 2'b00);
        end
        prdata = 32'hDEAD_BEEF;
        set_cmd(1'b0, 24'h000040, '0, 4'h0, 3'h0);
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        check("rst_after_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'hDEAD_BEEF});
        consume();

`ifdef APB_CMD_MASTER_TIMEOUT_EN
        // Timeout abort after 16 waited ACCESS cycles
        pready = 1'b0; prdata = 32'h7777_7777;
        set_cmd(1'b0, 24'h000080, '0, 4'h0, 3'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) begin
            tick();
            check($sformatf("tmo_wait%0d", i), {rsp_valid, psel, penable}, 3'b011);
        end
        tick();
        check("tmo_abort", {rsp_valid, rsp_err, rsp_rdata, psel, penable}, {1'b1, 1'b1, 32'h0, 2'b00});
        consume();

        // pready on the 16th waited cycle completes normally
        set_cmd(1'b0, 24'h000084, '0, 4'h0, 3'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) tick();
        check("tmo_edge_wait", {rsp_valid, penable}, 2'b01);
        pready = 1'b1; pslverr = 1'b0; prdata = 32'h0000_0055;
        tick();
        check("tmo_edge_done", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h0000_0055});
        consume();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- APB4 initiator: converts a valid/ready command stream into single APB transfers and returns each result on a valid/ready response channel.
- Opposite end of the APB slave ports on the peripheral subsystem and its fabric.
- Lets DMA or test engines, or any non-APB logic, drive register accesses into the fabric's master side.
- One transfer outstanding at a time; response held in a single-entry buffer.

Parameters:
ADDR, 24, APB address width (paddr, cmd_addr)
DATA, 32, APB data width; must be 8, 16 or 32; strobe width is DATA/8
TIMEOUT, 16, ACCESS-phase wait limit in cycles; used only with the optional feature; must be >= 1

Ports:
pclk  in  1  clock
preset  in  1  reset; synchronous to pclk, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR  transfer address
cmd_wdata  in  DATA  write data
cmd_strb  in  DATA/8  write byte strobes
cmd_prot  in  3  protection attributes
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  DATA  read data; 0 for writes
rsp_err  out  1  pslverr (or timeout) of the transfer
psel  out  1  APB select
penable  out  1  APB enable
pprot  out  3  APB protection
paddr  out  ADDR  APB address
pwrite  out  1  APB direction
pwdata  out  DATA  APB write data
pstrb  out  DATA/8  APB strobes
prdata  in  DATA  APB read data
pslverr  in  1  APB slave error
pready  in  1  APB ready

Behaviour:
- Reset:
  - While preset is high at a pclk edge: state goes to IDLE, and every output register is cleared to 0 (psel, penable, pprot, paddr, pwrite, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err).
  - cmd_ready is 0 during reset.
  - Reset mid-transfer abandons the transfer and drops any pending response; no response is ever produced for it.
- State machine has three states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready = !preset && (!rsp_valid || rsp_ready). This is combinational, so a response can be consumed in the same cycle a new command is accepted.
  - On acceptance, register cmd_* into the APB outputs. pstrb is forced to 0 for reads; paddr is passed unmodified, unaligned bits included.
  - Then go to SETUP.
- SETUP: psel=1, penable=0; unconditionally go to ACCESS.
- ACCESS:
  - psel=1, penable=1.
  - paddr, pwrite, pwdata, pstrb and pprot are held stable from SETUP until completion.
  - On a cycle with pready=1:
    - load rsp_rdata = pwrite ? 0 : prdata;
    - load rsp_err = pslverr (sampled only when pready=1);
    - set rsp_valid=1;
    - clear psel and penable;
    - go to IDLE.
  - While pready=0, stay in ACCESS.
- Latency:
  - Command accepted at edge N: SETUP during N..N+1, ACCESS from N+1.
  - With zero-wait pready, rsp_valid rises at edge N+2.
  - Minimum issue interval is 3 cycles; psel is low for at least 1 cycle between transfers.
- Response channel:
  - rsp_valid stays high and rsp_rdata/rsp_err stay stable until rsp_ready.
  - rsp_valid clears on the handshake edge unless a new response loads on that same edge. That cannot happen, because only one transfer is outstanding.
- cmd_* inputs are ignored outside the acceptance cycle. rsp_ready is ignored while rsp_valid=0.
- A write with cmd_strb=0 is still issued on the bus.
- No combinational path from any APB input to any APB output.

Optional Feature:
- Macro: APB_CMD_MASTER_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to ACCESS and increments on each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT while pready is still 0, the transfer is aborted: psel=0, penable=0, rsp_valid=1, rsp_err=1, rsp_rdata=0, state goes to IDLE.
  - pready=1 on the same cycle the count reaches TIMEOUT counts as a normal completion.
- Without the macro: no counter exists, ACCESS waits indefinitely, and TIMEOUT is unused.

Test Plan:
- Zero-wait write: cmd write addr 0x000010, wdata 0xA5A5_5A5A, strb 0xF, prot 0x2; slave pready=1 -> one SETUP and one ACCESS cycle with those values on paddr/pwdata/pstrb/pprot, then rsp_valid=1, rsp_rdata=0, rsp_err=0 two cycles after acceptance.
- Read with 3 wait states: read addr 0x000104; pready low for 3 ACCESS cycles, then high with prdata 0x1234_5678 -> paddr stable for 4 ACCESS cycles, pstrb=0, rsp_rdata=0x1234_5678.
- Slave error plus response backpressure: read returns pslverr=1 while rsp_ready=0 for 5 cycles -> rsp_valid and rsp_err=1 held stable; cmd_ready=0 throughout; rsp_ready=1 together with a pending cmd_valid -> both handshakes complete on the same edge.
- Back-to-back: 4 queued commands alternating write/read at addresses 0x0, 0x4, 0x8, 0xC with rsp_ready=1 -> 4 responses in order; psel low at least 1 cycle between transfers; no extra transfers issued.
- Reset in ACCESS: assert preset during a waited read -> next edge all outputs 0 and state IDLE; no response appears after reset releases, and the next command is serviced normally.
- Timeout (APB_CMD_MASTER_TIMEOUT_EN, TIMEOUT=16): pready held 0 -> abort after 16 ACCESS cycles with rsp_err=1 and rsp_rdata=0. Pready=1 exactly on the 16th waited cycle -> normal completion with rsp_err=pslverr.
